lcd_pixel_out: RTL and testbench



---
 rtl/lcd_pixel_out_if.sv | 40 ++++
 rtl/lcd_pixel_out.sv | 140 ++++++++++++++
 tb/tb_lcd_pixel_out.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pixel_out_if.sv
// Bus bundle between the pixel-formatting path, the timing controller and
// the lcd_pixel_out stage. The master side is the producer/timing-controller
// environment; the slave side is the pixel output stage itself.
//
// Handshake: write is a request without backpressure. A word is taken at a
// rising edge when write=1, full=0 and flush=0; otherwise it is dropped
// silently. read is a request from the timing controller. It pops at a
// rising edge when read=1, active=1, the FIFO is non-empty and flush=0. A
// popped pixel appears on lcdout one clock later, qualified by lcd_de=1.
interface lcd_pixel_out_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          tft_mode;
    logic [2:0]    bpp;
    logic          bgr;
    logic          write;
    logic [23:0]   wdata;
    logic          full;
    logic          almost_full;
    logic [LW-1:0] level;
    logic          flush;
    logic          read;
    logic          active;
    logic          underflow_clr;
    logic          underflow;
    logic [23:0]   lcdout;
    logic          lcd_de;

    modport master (
        output tft_mode, bpp, bgr, write, wdata, flush, read, active, underflow_clr,
        input  full, almost_full, level, underflow, lcdout, lcd_de
    );

    modport slave (
        input  tft_mode, bpp, bgr, write, wdata, flush, read, active, underflow_clr,
        output full, almost_full, level, underflow, lcdout, lcd_de
    );
endinterface

// File: rtl/lcd_pixel_out.sv
// Pixel output stage: a DEPTH-entry 24-bit FIFO shared by STN and TFT modes,
// followed by a pixel expander (STN zero-extend, TFT 24/565/444/1:555 with
// optional R/B swap) and a registered panel bus with data-enable. Reports
// occupancy, full/almost-full and a sticky underflow flag.
module lcd_pixel_out #(
    parameter int STN_W    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input logic            clk,
    input logic            reset,
    lcd_pixel_out_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [23:0]   STN_MASK = 24'((25'd1 << STN_W) - 25'd1);

    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [23:0]   r_lcdout;
    logic          r_lcd_de;
    logic          r_underflow;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_uf_set;
    logic [23:0]   w_head;
    logic [23:0]   w_exp;
    logic [23:0]   w_fmt;

    // Status flags come from the pre-edge count, so a push into a full FIFO
    // is refused even when a pop frees a slot in the same cycle.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_push   = bus.write & ~w_full & ~bus.flush;
    assign w_pop    = bus.read & bus.active & ~w_empty & ~bus.flush;
    assign w_uf_set = bus.active & bus.read & w_empty & ~bus.flush;
    assign w_head   = r_mem[r_rptr];

    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= AF_C);
    assign bus.level       = r_count;
    assign bus.lcdout      = r_lcdout;
    assign bus.lcd_de      = r_lcd_de;
    assign bus.underflow   = r_underflow;

    // Expand the head entry to the 24-bit panel bus per mode and format.
    always_comb begin
        w_exp = '0;
        if (!bus.tft_mode) begin
            w_exp = w_head & STN_MASK;
        end else begin
            case (bus.bpp)
                3'b101:  w_exp = w_head;
                3'b110:  w_exp = {w_head[15:11], 3'b0, w_head[10:5], 2'b0, w_head[4:0], 3'b0};
                3'b111:  w_exp = {w_head[11:8], 4'b0, w_head[7:4], 4'b0, w_head[3:0], 4'b0};
                default: w_exp = {w_head[14:10], w_head[15], 2'b0,
                                  w_head[9:5],   w_head[15], 2'b0,
                                  w_head[4:0],   w_head[15], 2'b0};
            endcase
        end
    end

    // BGR panels take red and blue in swapped byte lanes; STN ignores bgr.
    always_comb begin
        w_fmt = w_exp;
        if (bus.tft_mode && bus.bgr) begin
            w_fmt = {w_exp[7:0], w_exp[15:8], w_exp[23:16]};
        end
    end

    // Storage array: written on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush clears everything at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Panel output register: blank outside the window, load on pop,
    // blank on underflow, otherwise hold data with data-enable low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lcdout <= '0;
            r_lcd_de <= 1'b0;
        end else if (!bus.active) begin
            r_lcdout <= '0;
            r_lcd_de <= 1'b0;
        end else if (w_pop) begin
            r_lcdout <= w_fmt;
            r_lcd_de <= 1'b1;
        end else if (w_uf_set) begin
            r_lcdout <= '0;
            r_lcd_de <= 1'b0;
        end else begin
            r_lcd_de <= 1'b0;
        end
    end

    // Sticky underflow: a new event wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_underflow <= 1'b0;
        end else if (w_uf_set) begin
            r_underflow <= 1'b1;
        end else if (bus.underflow_clr) begin
            r_underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lcd_pixel_out.sv
// Self-checking bench for lcd_pixel_out (STN_W=8, DEPTH=4, AF_LEVEL=3).
module tb_lcd_pixel_out;
    localparam int STN_W    = 8;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;

    logic clk;
    logic reset;

    lcd_pixel_out_if #(.DEPTH(DEPTH)) bus ();

    lcd_pixel_out #(
        .STN_W    (STN_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard and reference model.
    logic [23:0] exp_q[$];
    logic [23:0] model_q[$];
    logic [23:0] exp_lcdout;
    logic        exp_de;
    logic        exp_uf;

    function automatic logic [23:0] ref_fmt(input logic [23:0] h, input logic tft,
                                            input logic [2:0] b, input logic sw);
        logic [7:0] r, g, bl;
        r = 8'h0; g = 8'h0; bl = 8'h0;
        if (!tft) return {16'h0, h[7:0]};
        case (b)
            3'b101:  begin r = h[23:16]; g = h[15:8]; bl = h[7:0]; end
            3'b110:  begin r = {h[15:11], 3'b000}; g = {h[10:5], 2'b00}; bl = {h[4:0], 3'b000}; end
            3'b111:  begin r = {h[11:8], 4'h0}; g = {h[7:4], 4'h0}; bl = {h[3:0], 4'h0}; end
            default: begin r = {h[14:10], h[15], 2'b00}; g = {h[9:5], h[15], 2'b00}; bl = {h[4:0], h[15], 2'b00}; end
        endcase
        if (sw) return {bl, g, r};
        return {r, g, bl};
    endfunction

    // Driver: applies one cycle of stimulus, advances the model, then waits
    // until 1 time unit after the edge so outputs can be sampled.
    task automatic drive(input logic wr, input logic [23:0] wd, input logic rd,
                         input logic act, input logic fl, input logic uclr);
        bit push_ok, pop_ok, uf_set;
        bus.write = wr; bus.wdata = wd; bus.read = rd;
        bus.active = act; bus.flush = fl; bus.underflow_clr = uclr;
        push_ok = wr && (model_q.size() < DEPTH) && !fl;
        pop_ok  = rd && act && (model_q.size() != 0) && !fl;
        uf_set  = act && rd && (model_q.size() == 0) && !fl;
        if (!act) begin
            exp_lcdout = '0; exp_de = 1'b0;
        end else if (pop_ok) begin
            exp_lcdout = ref_fmt(model_q[0], bus.tft_mode, bus.bpp, bus.bgr);
            exp_de = 1'b1;
            exp_q.push_back(exp_lcdout);
        end else if (uf_set) begin
            exp_lcdout = '0; exp_de = 1'b0;
        end else begin
            exp_de = 1'b0;
        end
        if (uf_set) exp_uf = 1'b1;
        else if (uclr) exp_uf = 1'b0;
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(wd);
        end
        @(posedge clk); #1;
        bus.write = 1'b0; bus.read = 1'b0; bus.flush = 1'b0; bus.underflow_clr = 1'b0;
    endtask

    task automatic apply_reset(input logic wr, input logic rd, input logic act);
        reset = 1'b0;
        bus.write = wr; bus.wdata = 24'hABCDEF; bus.read = rd; bus.active = act;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.write = 1'b0; bus.read = 1'b0;
        model_q.delete();
        exp_lcdout = '0; exp_de = 1'b0; exp_uf = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.level !== 3'd0) begin n_errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
        n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_checks++; if (bus.almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_af got %b want 0", bus.almost_full); end
        n_checks++; if (bus.lcdout !== 24'h0) begin n_errors++; $display("FAIL reset_lcdout got %h want 000000", bus.lcdout); end
        n_checks++; if (bus.lcd_de !== 1'b0) begin n_errors++; $display("FAIL reset_de got %b want 0", bus.lcd_de); end
        n_checks++; if (bus.underflow !== 1'b0) begin n_errors++; $display("FAIL reset_uf got %b want 0", bus.underflow); end
    endtask

    task automatic test_fill_drain();
        logic [23:0] w, e;
        bus.tft_mode = 1'b0; bus.bpp = 3'b000; bus.bgr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 24'(24'h11 * (i + 1));
            drive(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0);
            n_checks++; if (bus.level !== 3'(i + 1)) begin n_errors++; $display("FAIL fill_level[%0d] got %0d want %0d", i, bus.level, i + 1); end
            n_checks++; if (bus.almost_full !== (i + 1 >= AF_LEVEL)) begin n_errors++; $display("FAIL fill_af[%0d] got %b want %b", i, bus.almost_full, (i + 1 >= AF_LEVEL)); end
        end
        n_checks++; if (bus.full !== 1'b1) begin n_errors++; $display("FAIL fill_full got %b want 1", bus.full); end
        drive(1'b1, 24'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 3'd4) begin n_errors++; $display("FAIL drop_level got %0d want 4", bus.level); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            w = 24'(24'h11 * (i + 1));
            n_checks++; if (bus.lcd_de !== 1'b1) begin n_errors++; $display("FAIL drain_de[%0d] got %b want 1", i, bus.lcd_de); end
            n_checks++; if (bus.lcdout !== w) begin n_errors++; $display("FAIL drain_data[%0d] got %h want %h", i, bus.lcdout, w); end
            if (bus.lcd_de === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++; if (bus.lcdout !== e) begin n_errors++; $display("FAIL drain_sb[%0d] got %h want %h", i, bus.lcdout, e); end
            end
        end
        n_checks++; if (bus.level !== 3'd0) begin n_errors++; $display("FAIL drain_level got %0d want 0", bus.level); end
        drive(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.lcd_de !== 1'b0 || bus.lcdout !== 24'h44) begin n_errors++; $display("FAIL hold got de=%b out=%h want de=0 out=000044", bus.lcd_de, bus.lcdout); end
        // Active falling with a pending read: blanks, pops nothing.
        drive(1'b1, 24'h66, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.lcdout !== 24'h0 || bus.lcd_de !== 1'b0) begin n_errors++; $display("FAIL inactive_out got de=%b out=%h want de=0 out=000000", bus.lcd_de, bus.lcdout); end
        n_checks++; if (bus.level !== 3'd1) begin n_errors++; $display("FAIL inactive_level got %0d want 1", bus.level); end
        drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.lcdout !== e || bus.lcd_de !== 1'b1) begin n_errors++; $display("FAIL inactive_pop got %h want %h", bus.lcdout, e); end
        end
    endtask

    task automatic test_tft_formats();
        logic [23:0] t_word [8];
        logic [2:0]  t_bpp  [8];
        logic        t_bgr  [8];
        logic        t_tft  [8];
        logic [23:0] t_exp  [8];
        logic [23:0] e;
        t_word[0] = 24'h00F81F; t_bpp[0] = 3'b110; t_bgr[0] = 1'b0; t_tft[0] = 1'b1; t_exp[0] = 24'hF800F8;
        t_word[1] = 24'hFF0ABC; t_bpp[1] = 3'b111; t_bgr[1] = 1'b0; t_tft[1] = 1'b1; t_exp[1] = 24'hA0B0C0;
        t_word[2] = 24'h008000; t_bpp[2] = 3'b000; t_bgr[2] = 1'b0; t_tft[2] = 1'b1; t_exp[2] = 24'h040404;
        t_word[3] = 24'h123456; t_bpp[3] = 3'b101; t_bgr[3] = 1'b1; t_tft[3] = 1'b1; t_exp[3] = 24'h563412;
        t_word[4] = 24'h123456; t_bpp[4] = 3'b101; t_bgr[4] = 1'b0; t_tft[4] = 1'b1; t_exp[4] = 24'h123456;
        t_word[5] = 24'h00F800; t_bpp[5] = 3'b110; t_bgr[5] = 1'b1; t_tft[5] = 1'b1; t_exp[5] = 24'h0000F8;
        t_word[6] = 24'h1234AB; t_bpp[6] = 3'b101; t_bgr[6] = 1'b1; t_tft[6] = 1'b0; t_exp[6] = 24'h0000AB;
        t_word[7] = 24'h007C00; t_bpp[7] = 3'b011; t_bgr[7] = 1'b0; t_tft[7] = 1'b1; t_exp[7] = 24'hF80000;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, t_word[i], 1'b0, 1'b0, 1'b0, 1'b0);
            bus.tft_mode = t_tft[i]; bus.bpp = t_bpp[i]; bus.bgr = t_bgr[i];
            drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++; if (bus.lcd_de !== 1'b1 || bus.lcdout !== t_exp[i]) begin n_errors++; $display("FAIL fmt[%0d] got de=%b out=%h want de=1 out=%h", i, bus.lcd_de, bus.lcdout, t_exp[i]); end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++; if (bus.lcdout !== e) begin n_errors++; $display("FAIL fmt_sb[%0d] got %h want %h", i, bus.lcdout, e); end
            end
        end
        bus.tft_mode = 1'b0; bus.bpp = 3'b000; bus.bgr = 1'b0;
    endtask

    task automatic test_underflow();
        logic [23:0] e;
        drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.underflow !== 1'b1) begin n_errors++; $display("FAIL uf_set got %b want 1", bus.underflow); end
        n_checks++; if (bus.lcdout !== 24'h0 || bus.lcd_de !== 1'b0) begin n_errors++; $display("FAIL uf_out got de=%b out=%h want de=0 out=000000", bus.lcd_de, bus.lcdout); end
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (bus.underflow !== 1'b1) begin n_errors++; $display("FAIL uf_flush got %b want 1", bus.underflow); end
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.underflow !== 1'b0) begin n_errors++; $display("FAIL uf_clr got %b want 0", bus.underflow); end
        drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.underflow !== 1'b1) begin n_errors++; $display("FAIL uf_set_vs_clr got %b want 1", bus.underflow); end
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Push and read together on an empty FIFO: underflow, word kept.
        drive(1'b1, 24'h0000C3, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.underflow !== 1'b1 || bus.lcd_de !== 1'b0) begin n_errors++; $display("FAIL uf_push got uf=%b de=%b want uf=1 de=0", bus.underflow, bus.lcd_de); end
        n_checks++; if (bus.level !== 3'd1) begin n_errors++; $display("FAIL uf_push_level got %0d want 1", bus.level); end
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.underflow !== exp_uf || bus.lcd_de !== 1'b1) begin n_errors++; $display("FAIL uf_pop got uf=%b de=%b want uf=%b de=1", bus.underflow, bus.lcd_de, exp_uf); end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.lcdout !== e) begin n_errors++; $display("FAIL uf_pop_data got %h want %h", bus.lcdout, e); end
        end
    endtask

    task automatic test_full_traffic();
        logic [23:0] e;
        for (int i = 0; i < 4; i++) drive(1'b1, 24'(24'hA1 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 24'h0000BB, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.level !== 3'd3) begin n_errors++; $display("FAIL full_rw_level got %0d want 3", bus.level); end
        n_checks++; if (bus.lcdout !== 24'h0000A1 || bus.lcd_de !== 1'b1) begin n_errors++; $display("FAIL full_rw_data got de=%b out=%h want de=1 out=0000A1", bus.lcd_de, bus.lcdout); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++; if (bus.lcdout !== e || bus.lcd_de !== 1'b1) begin n_errors++; $display("FAIL full_drain[%0d] got %h want %h", i, bus.lcdout, e); end
            end
        end
        // Flush drops contents and ignores a concurrent push and read.
        for (int i = 0; i < 3; i++) drive(1'b1, 24'(24'hD0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 24'h0000EE, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++; if (bus.level !== 3'd0 || bus.lcd_de !== 1'b0) begin n_errors++; $display("FAIL flush got level=%0d de=%b want level=0 de=0", bus.level, bus.lcd_de); end
        n_checks++; if (bus.underflow !== exp_uf) begin n_errors++; $display("FAIL flush_uf got %b want %b", bus.underflow, exp_uf); end
    endtask

    task automatic test_wrap();
        logic [23:0] e;
        for (int i = 0; i < 2; i++) drive(1'b1, 24'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 24'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 1'b0);
            n_checks++; if (bus.almost_full !== 1'b1 || bus.level !== 3'd3) begin n_errors++; $display("FAIL wrap_af_on[%0d] got af=%b level=%0d want af=1 level=3", i, bus.almost_full, bus.level); end
            drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++; if (bus.almost_full !== 1'b0) begin n_errors++; $display("FAIL wrap_af_off[%0d] got %b want 0", i, bus.almost_full); end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++; if (bus.lcdout !== e || bus.lcd_de !== 1'b1) begin n_errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, bus.lcdout, e); end
            end
        end
        // Simultaneous push and pop at level 2: one pixel per clock, level steady.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 24'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++; if (bus.level !== 3'd2 || bus.lcd_de !== 1'b1) begin n_errors++; $display("FAIL b2b[%0d] got level=%0d de=%b want level=2 de=1", i, bus.level, bus.lcd_de); end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++; if (bus.lcdout !== e) begin n_errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, bus.lcdout, e); end
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++; if (bus.lcdout !== e) begin n_errors++; $display("FAIL wrap_tail[%0d] got %h want %h", i, bus.lcdout, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] e;
        for (int i = 0; i < 4; i++) drive(1'b1, 24'(24'h31 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        apply_reset(1'b1, 1'b1, 1'b1);
        n_checks++; if (bus.level !== 3'd0) begin n_errors++; $display("FAIL mid_reset_level got %0d want 0", bus.level); end
        n_checks++; if (bus.lcdout !== 24'h0 || bus.lcd_de !== 1'b0) begin n_errors++; $display("FAIL mid_reset_out got de=%b out=%h want de=0 out=000000", bus.lcd_de, bus.lcdout); end
        drive(1'b1, 24'h00005A, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.lcdout !== 24'h00005A || bus.lcd_de !== 1'b1) begin n_errors++; $display("FAIL mid_reset_rt got de=%b out=%h want de=1 out=00005A", bus.lcd_de, bus.lcdout); end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.lcdout !== e) begin n_errors++; $display("FAIL mid_reset_sb got %h want %h", bus.lcdout, e); end
        end
    endtask

    initial begin
        bus.tft_mode = 1'b0; bus.bpp = 3'b000; bus.bgr = 1'b0;
        bus.write = 1'b0; bus.wdata = '0; bus.flush = 1'b0;
        bus.read = 1'b0; bus.active = 1'b0; bus.underflow_clr = 1'b0;
        exp_lcdout = '0; exp_de = 1'b0; exp_uf = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        test_reset();
        test_fill_drain();
        test_tft_formats();
        test_underflow();
        test_full_traffic();
        test_wrap();
        test_reset_mid();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
